// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory through the CPU's external port, then enables the CPU.
// Defining IMEM_LOADER_VERIFY_EN adds a readback pass that checks a checksum before releasing the CPU.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int          CNT_W     = 10,
    parameter int          RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic [31:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // IDLE wait for start | LOAD stream words in | VERIFY readback sum | RUN cpu enabled | ERROR readback mismatch
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_RUN, ST_ERROR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             s_ready_q, s_ready_d;
    logic             wen_q, wen_d;
    logic             cpu_en_q, cpu_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hs;

    assign hs = s_valid && s_ready_q;

`ifdef IMEM_LOADER_VERIFY_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rd_rem_q, rd_rem_d;
    logic [CNT_W-1:0]  smp_rem_q, smp_rem_d;
    logic [31:0]       csum_q, csum_d;
    logic [31:0]       rsum_q, rsum_d, rsum_next;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic              ren_q, ren_d;
    logic              error_q, error_d;
    logic              smp, last_smp;

    // pipe_q tracks reads in flight; its top bit marks the cycle rdata_ext is valid
    assign smp       = pipe_q[RD_LAT-1];
    assign rsum_next = rsum_q + rdata_ext;
    assign last_smp  = (state_q == ST_VERIFY) && smp && (smp_rem_q == CNT_W'(1));
    assign ren_ext   = ren_q;
    assign error     = error_q;
`else
    logic unused_ok;
    assign unused_ok = ^rdata_ext;
    assign ren_ext   = 1'b0;
    assign error     = 1'b0;
`endif

    assign s_ready    = s_ready_q;
    assign addr_ext   = addr_q;
    assign wen_ext    = wen_q;
    assign wdata_ext  = wdata_q;
    assign cpu_enable = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && word_count != '0) state_d = ST_LOAD;
                ST_LOAD: begin
                    if (rem_q == '0) begin
`ifdef IMEM_LOADER_VERIFY_EN
                        state_d = ST_VERIFY;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
`ifdef IMEM_LOADER_VERIFY_EN
                ST_VERIFY: if (last_smp) state_d = (rsum_next == csum_q) ? ST_RUN : ST_ERROR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        rd_rem_d  = rd_rem_q;
        smp_rem_d = smp_rem_q;
        rsum_d    = rsum_q;
        pipe_d    = '0;
        ren_d     = 1'b0;
`endif
        if (!abort) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && word_count != '0) begin
                        rem_d = word_count;
                        ptr_d = BASE_ADDR;
`ifdef IMEM_LOADER_VERIFY_EN
                        cnt_d  = word_count;
                        csum_d = '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        wen_d   = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = s_data;
                        ptr_d   = ptr_q + ADDR_STEP;
                        rem_d   = rem_q - CNT_W'(1);
`ifdef IMEM_LOADER_VERIFY_EN
                        csum_d  = csum_q + s_data;
`endif
                    end
`ifdef IMEM_LOADER_VERIFY_EN
                    if (rem_q == '0) begin
                        ptr_d     = BASE_ADDR;
                        rd_rem_d  = cnt_q;
                        smp_rem_d = cnt_q;
                        rsum_d    = '0;
                    end
`endif
                end
`ifdef IMEM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    pipe_d = (pipe_q << 1) | RD_LAT'(ren_q);
                    if (rd_rem_q != '0) begin
                        ren_d    = 1'b1;
                        addr_d   = ptr_q;
                        ptr_d    = ptr_q + ADDR_STEP;
                        rd_rem_d = rd_rem_q - CNT_W'(1);
                    end
                    if (smp) begin
                        rsum_d    = rsum_next;
                        smp_rem_d = smp_rem_q - CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
        // s_ready drops the cycle after the handshake that empties the count
        s_ready_d = (state_d == ST_LOAD) && (rem_d != '0);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
        done_d    = (state_d == ST_RUN);
        cpu_en_d  = (state_d == ST_RUN);
`ifdef IMEM_LOADER_VERIFY_EN
        error_d   = (state_d == ST_ERROR);
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rem_q     <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            s_ready_q <= 1'b0;
            cpu_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            cnt_q     <= '0;
            csum_q    <= '0;
            rd_rem_q  <= '0;
            smp_rem_q <= '0;
            rsum_q    <= '0;
            pipe_q    <= '0;
            ren_q     <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            rem_q     <= rem_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            s_ready_q <= s_ready_d;
            cpu_en_q  <= cpu_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef IMEM_LOADER_VERIFY_EN
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            rd_rem_q  <= rd_rem_d;
            smp_rem_q <= smp_rem_d;
            rsum_q    <= rsum_d;
            pipe_q    <= pipe_d;
            ren_q     <= ren_d;
            error_q   <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at stimulus time and popped by a write monitor.
// A second instance with BASE_ADDR=0xFFFFFFFC covers address wrap.
module tb_imem_loader;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             arst_n, start, start_w, abort, s_valid;
    logic [CNT_W-1:0] word_count;
    logic [31:0]      s_data;
    logic             s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
    logic [31:0]      addr_ext, wdata_ext;
    logic [31:0]      rdata_ext = 32'h0;
    logic             s_ready_w, wen_w, ren_w, cpu_en_w, busy_w, done_w, error_w;
    logic [31:0]      addr_w, wdata_w;
    logic [31:0]      rdata_w = 32'h0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w[$];
    logic [31:0] mem_a[64];
    logic [31:0] mem_w[64];
    logic        corrupt = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .arst_n(arst_n), .start(start), .word_count(word_count), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .rdata_ext(rdata_ext), .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .CNT_W(CNT_W)) u_wrap (
        .clk(clk), .arst_n(arst_n), .start(start_w), .word_count(word_count), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_w),
        .addr_ext(addr_w), .wen_ext(wen_w), .ren_ext(ren_w), .wdata_ext(wdata_w),
        .rdata_ext(rdata_w), .cpu_enable(cpu_en_w), .busy(busy_w), .done(done_w), .error(error_w)
    );

    // external memory, one-cycle read latency; corrupt forces word 1 to read back as 2|1
    always @(posedge clk) begin
        if (wen_ext) mem_a[addr_ext[7:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= mem_a[addr_ext[7:2]] | ((corrupt && addr_ext[7:2] == 6'd1) ? 32'h1 : 32'h0);
        if (wen_w) mem_w[addr_w[7:2]] <= wdata_w;
        if (ren_w) rdata_w <= mem_w[addr_w[7:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (wen_ext === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", addr_ext, wdata_ext);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", addr_ext, e[63:32]);
                check("write_data", wdata_ext, e[31:0]);
            end
        end
        if (wen_w === 1'b1) begin
            if (exp_w.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write_wrap: got addr %h data %h expected no write", addr_w, wdata_w);
            end else begin
                e = exp_w.pop_front();
                check("wrap_write_addr", addr_w, e[63:32]);
                check("wrap_write_data", wdata_w, e[31:0]);
            end
        end
`ifndef IMEM_LOADER_VERIFY_EN
        if (ren_ext === 1'b1 || ren_w === 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL ren_tied: got ren_ext 1 expected 0");
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit wr, input logic [CNT_W-1:0] cnt);
        word_count = cnt;
        if (wr) start_w = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0;
        start_w = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // queue the expected write, present the word, wait (bounded) for the handshake edge
    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        bit got = 1'b0;
        if (wr) exp_w.push_back({addr, data}); else exp_q.push_back({addr, data});
        s_valid = 1'b1;
        s_data  = data;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if ((wr ? s_ready_w : s_ready) === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got s_ready 0 expected 1 for data %h", data);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_end(input bit wr);
        bit fin = 1'b0;
        for (int t = 0; t < 40 && !fin; t++) begin
            @(negedge clk);
            if (wr ? (done_w | error_w) : (done | error)) fin = 1'b1;
        end
        if (!fin) begin
            n_cmp++; n_err++;
            $display("FAIL end_timeout: got no done/error expected one within 40 cycles");
        end
    endtask

    initial begin
        arst_n = 1'b0; start = 1'b0; start_w = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; word_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'h0);
        check("rst_wen", 32'(wen_ext), 32'h0);
        check("rst_ren", 32'(ren_ext), 32'h0);
        check("rst_addr", addr_ext, 32'h0);
        check("rst_cpu_enable", 32'(cpu_enable), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        tick();
        arst_n = 1'b1;
        tick();

        // basic back-to-back load
        pulse_start(1'b0, 10'd3);
        send(1'b0, 32'h0, 32'h2001_0005);
        send(1'b0, 32'h4, 32'h2002_0007);
        send(1'b0, 32'h8, 32'h0022_1820);
        @(negedge clk);
        check("last_s_ready", 32'(s_ready), 32'h0);
        check("last_busy", 32'(busy), 32'h1);
        check("last_cpu_enable", 32'(cpu_enable), 32'h0);
        wait_end(1'b0);
        check("basic_done", 32'(done), 32'h1);
        check("basic_cpu_enable", 32'(cpu_enable), 32'h1);
        check("basic_error", 32'(error), 32'h0);
        check("basic_busy", 32'(busy), 32'h0);
        check("basic_pending", 32'(exp_q.size()), 32'h0);

        // start and stream noise in RUN are ignored
        s_valid = 1'b1;
        pulse_start(1'b0, 10'd3);
        tick();
        @(negedge clk);
        check("run_hold_done", 32'(done), 32'h1);
        check("run_s_ready", 32'(s_ready), 32'h0);
        s_valid = 1'b0;
        do_abort();
        @(negedge clk);
        check("abort_run_cpu_enable", 32'(cpu_enable), 32'h0);
        check("abort_run_done", 32'(done), 32'h0);

        // stalled stream
        pulse_start(1'b0, 10'd3);
        send(1'b0, 32'h0, 32'h2001_0005);
        tick(); tick();
        send(1'b0, 32'h4, 32'h2002_0007);
        tick(); tick();
        send(1'b0, 32'h8, 32'h0022_1820);
        wait_end(1'b0);
        check("stall_done", 32'(done), 32'h1);
        check("stall_pending", 32'(exp_q.size()), 32'h0);
        do_abort();

        // zero count with stream noise
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        pulse_start(1'b0, 10'd0);
        tick(); tick();
        @(negedge clk);
        check("zero_s_ready", 32'(s_ready), 32'h0);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_cpu_enable", 32'(cpu_enable), 32'h0);
        s_valid = 1'b0;

        // abort together with the second handshake
        pulse_start(1'b0, 10'd4);
        send(1'b0, 32'h0, 32'h1111_0001);
        s_valid = 1'b1;
        s_data  = 32'h1111_0002;
        abort   = 1'b1;
        @(negedge clk);
        check("abort_cycle_s_ready", 32'(s_ready), 32'h1);
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("abort_wen", 32'(wen_ext), 32'h0);
        check("abort_s_ready", 32'(s_ready), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_cpu_enable", 32'(cpu_enable), 32'h0);
        pulse_start(1'b0, 10'd1);
        send(1'b0, 32'h0, 32'h2222_0001);
        wait_end(1'b0);
        check("reload_done", 32'(done), 32'h1);
        check("reload_pending", 32'(exp_q.size()), 32'h0);
        do_abort();

`ifdef IMEM_LOADER_VERIFY_EN
        // readback mismatch then match
        corrupt = 1'b1;
        pulse_start(1'b0, 10'd2);
        send(1'b0, 32'h0, 32'h1);
        send(1'b0, 32'h4, 32'h2);
        wait_end(1'b0);
        check("verify_bad_error", 32'(error), 32'h1);
        check("verify_bad_cpu_enable", 32'(cpu_enable), 32'h0);
        check("verify_bad_done", 32'(done), 32'h0);
        do_abort();
        @(negedge clk);
        check("verify_abort_error", 32'(error), 32'h0);
        corrupt = 1'b0;
        pulse_start(1'b0, 10'd2);
        send(1'b0, 32'h0, 32'h1);
        send(1'b0, 32'h4, 32'h2);
        wait_end(1'b0);
        check("verify_good_done", 32'(done), 32'h1);
        check("verify_good_error", 32'(error), 32'h0);
        do_abort();
`endif

        // address wrap on the second instance
        pulse_start(1'b1, 10'd2);
        send(1'b1, 32'hFFFF_FFFC, 32'hA5A5_0001);
        send(1'b1, 32'h0000_0000, 32'hA5A5_0002);
        wait_end(1'b1);
        check("wrap_done", 32'(done_w), 32'h1);
        check("wrap_cpu_enable", 32'(cpu_en_w), 32'h1);
        check("wrap_error", 32'(error_w), 32'h0);
        do_abort();
        tick();

        check("final_pending", 32'(exp_q.size()), 32'h0);
        check("final_pending_wrap", 32'(exp_w.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
